// File: rtl/serial_subtractor_nbit.sv
// serial_subtractor_nbit
// Multi-cycle subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per
// clock through a DIGIT-wide ripple-borrow chain, borrow held between digits.
// Start/done handshake; reports borrow, zero and signed-overflow flags.
// Optional build macro SUB_ADD_MODE_EN adds a 'mode' input selecting
// addition (mode=1, bin acts as carry-in, bout as carry-out).
module serial_subtractor_nbit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
`ifdef SUB_ADD_MODE_EN
  input  logic             mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
    $error("serial_subtractor_nbit: WIDTH must be an integer multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             mode_eff;

`ifdef SUB_ADD_MODE_EN
  logic             mode_q, mode_d;
  assign mode_eff = mode_q;
`else
  assign mode_eff = 1'b0;
`endif

  // One DIGIT-wide ripple step; returns {borrow/carry out, digit result}.
  function automatic logic [DIGIT:0] digit_step(input logic [DIGIT-1:0] x,
                                                input logic [DIGIT-1:0] y,
                                                input logic             br_in,
                                                input logic             add);
    logic [DIGIT-1:0] d;
    logic             br;
    br = br_in;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = x[i] ^ y[i] ^ br;
      if (add) br = (x[i] & y[i]) | ((x[i] ^ y[i]) & br);
      else     br = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
    end
    return {br, d};
  endfunction

  // Signed overflow from the captured operand sign bits and the result sign.
  function automatic logic ovf_calc(input logic am, input logic bm,
                                    input logic dm, input logic add);
    if (add) return (am == bm) && (dm != am);
    else     return (am != bm) && (dm != am);
  endfunction

  logic [DIGIT:0]         step;
  logic [WIDTH+DIGIT-1:0] diff_cat;

  assign step     = digit_step(a_q[DIGIT-1:0], b_q[DIGIT-1:0], br_q, mode_eff);
  assign diff_cat = {step[DIGIT-1:0], diff_q};

  // Next-state and datapath update: accept in IDLE/FIN, one digit per RUN cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`ifdef SUB_ADD_MODE_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
          cnt_d   = '0;
`ifdef SUB_ADD_MODE_EN
          mode_d  = mode;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d = diff_cat[WIDTH+DIGIT-1:DIGIT];
        a_d    = a_q >> DIGIT;
        b_d    = b_q >> DIGIT;
        br_d   = step[DIGIT];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          bout_d  = step[DIGIT];
          zero_d  = (diff_d == '0);
          ovf_d   = ovf_calc(amsb_q, bmsb_q, diff_d[WIDTH-1], mode_eff);
          cnt_d   = '0;
          state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SUB_ADD_MODE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`ifdef SUB_ADD_MODE_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == FIN);
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// tb_serial_subtractor_nbit
// Randomized and directed bench for serial_subtractor_nbit (WIDTH=8, DIGIT=2)
// against a plain-arithmetic reference model. Honors SUB_ADD_MODE_EN.
module tb_serial_subtractor_nbit;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int N     = WIDTH / DIGIT;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  int checks   = 0;
  int failures = 0;

  serial_subtractor_nbit #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
`ifdef SUB_ADD_MODE_EN
    .mode  (mode),
`endif
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: {bout, zero, ovf, diff} from plain arithmetic.
  function automatic logic [WIDTH+2:0] model(input logic [WIDTH-1:0] ma,
                                             input logic [WIDTH-1:0] mb,
                                             input logic mbin, input logic mmode);
    int unsigned r;
    logic [WIDTH-1:0] d;
    logic bo, z, ov;
    if (mmode) begin
      r  = int'(ma) + int'(mb) + int'(mbin);
      d  = r[WIDTH-1:0];
      bo = (r >= (1 << WIDTH));
      ov = (ma[WIDTH-1] == mb[WIDTH-1]) && (d[WIDTH-1] != ma[WIDTH-1]);
    end else begin
      bo = (int'(ma) < int'(mb) + int'(mbin));
      r  = int'(ma) - int'(mb) - int'(mbin) + (1 << WIDTH);
      d  = r[WIDTH-1:0];
      ov = (ma[WIDTH-1] != mb[WIDTH-1]) && (d[WIDTH-1] != ma[WIDTH-1]);
    end
    z = (d == '0);
    return {bo, z, ov, d};
  endfunction

  task automatic chk_result(input string tag, input logic [WIDTH+2:0] e);
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".busy_fin"}, busy, 1'b0);
    chk({tag, ".diff"}, diff, e[WIDTH-1:0]);
    chk({tag, ".ovf"}, ovf, e[WIDTH]);
    chk({tag, ".zero"}, zero, e[WIDTH+1]);
    chk({tag, ".bout"}, bout, e[WIDTH+2]);
  endtask

  // One isolated operation; operands are scrambled during RUN.
  task automatic do_op(input string tag, input logic [WIDTH-1:0] ta,
                       input logic [WIDTH-1:0] tb, input logic tbin, input logic tmode);
    logic [WIDTH+2:0] e;
    e = model(ta, tb, tbin, tmode);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; mode = tmode; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk({tag, ".busy"}, busy, 1'b1);
      chk({tag, ".nodone"}, done, 1'b0);
      a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
      if (k == 1) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk_result(tag, e);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, done, 1'b0);
  endtask

  logic [WIDTH+2:0] e;
  logic [WIDTH-1:0] ra, rb;
  logic             rbin, rmode;

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.diff", diff, '0);
    chk("rst.flags", {bout, zero, ovf}, 3'b000);
    reset = 1'b0;

    do_op("t1", 8'h5A, 8'h1F, 1'b0, 1'b0);
    do_op("t2a", 8'h10, 8'h20, 1'b1, 1'b0);
    do_op("t2b", 8'h80, 8'h01, 1'b0, 1'b0);
    do_op("t3", 8'h33, 8'h33, 1'b0, 1'b0);
    e = model(8'h33, 8'h33, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      @(posedge clk); #1;
      chk("t3.hold", {busy, done, bout, zero, ovf, diff}, {2'b00, e[WIDTH+2:WIDTH], e[WIDTH-1:0]});
    end
    do_op("edge0", 8'h00, 8'h00, 1'b1, 1'b0);
    do_op("edgeFF", 8'hFF, 8'hFF, 1'b0, 1'b0);
    do_op("edgeOv", 8'h7F, 8'hFF, 1'b0, 1'b0);

    // Back-to-back: start held high, new operands presented in each FIN cycle.
    @(negedge clk);
    ra = WIDTH'($urandom); rb = WIDTH'($urandom); rbin = 1'($urandom);
    a = ra; b = rb; bin = rbin; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int op = 0; op < 6; op++) begin
      e = model(ra, rb, rbin, 1'b0);
      for (int k = 0; k < N; k++) begin
        chk("b2b.busy", busy, 1'b1);
        a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
        @(posedge clk); #1;
      end
      chk_result("b2b", e);
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rbin = 1'($urandom);
      a = ra; b = rb; bin = rbin;
      @(posedge clk); #1;
    end
    chk("b2b.reaccept", busy, 1'b1);
    start = 1'b0;
    repeat (N + 2) @(posedge clk);
    #1;

    // Reset in the second RUN cycle aborts the operation.
    @(negedge clk);
    a = 8'h12; b = 8'h34; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort.busy_run2", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort.busy", busy, 1'b0);
    chk("abort.done", done, 1'b0);
    chk("abort.diff", diff, '0);
    chk("abort.flags", {bout, zero, ovf}, 3'b000);
    for (int k = 0; k < N + 2; k++) begin
      @(posedge clk); #1;
      chk("abort.nodone", {busy, done}, 2'b00);
    end
    do_op("after_abort", 8'h12, 8'h34, 1'b0, 1'b0);

`ifdef SUB_ADD_MODE_EN
    do_op("add1", 8'h7F, 8'h01, 1'b0, 1'b1);
    do_op("add2", 8'hFF, 8'h01, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      rmode = 1'b0;
`ifdef SUB_ADD_MODE_EN
      rmode = 1'($urandom);
`endif
      do_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), rmode);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
